// File: rtl/piso.sv
`default_nettype none
// ============================================================================
// Module   : piso
// Purpose  : Parallel-in, serial-out shift register for the PMU bitstream
//            path. Captures a WIDTH-bit word in one cycle, then emits one bit
//            per enabled clock on data_o with valid_o marking unsent bits.
// Config   : PISO_LSB_FIRST_EN -- when defined, the word is emitted LSB
//            first (right shift); otherwise MSB first (left shift).
// Revision : 1.0 - initial release
// ============================================================================
module piso #(
    parameter int WIDTH = 128,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,      // synchronous, active-low
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] data_i,
    output logic             data_o,
    output logic             valid_o
);

    // Counter value loaded with a fresh word: every bit is still unsent.
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic [CNT_W-1:0] w_cnt_dec;

`ifdef PISO_LSB_FIRST_EN
    // LSB-first: the head bit lives at bit 0, shift right with zero fill.
    assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
    assign data_o         = r_sreg[0];
`else
    // MSB-first: the head bit lives at the top, shift left with zero fill.
    assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
    assign data_o         = r_sreg[WIDTH-1];
`endif

    // Remaining-bit count saturates at zero so an idle shifter keeps
    // clocking zeros without wrapping back to a "valid" state.
    assign w_cnt_dec = (r_cnt == c_cnt_zero) ? c_cnt_zero : (r_cnt - c_cnt_one);

    assign valid_o = (r_cnt != c_cnt_zero);

    // Register update: reset beats load, load beats shift, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sreg <= '0;
            r_cnt  <= c_cnt_zero;
        end else if (load) begin
            r_sreg <= data_i;
            r_cnt  <= c_cnt_full;
        end else if (en) begin
            r_sreg <= w_sreg_shifted;
            r_cnt  <= w_cnt_dec;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_piso
// Purpose  : Self-checking bench for piso. A word/index model predicts the
//            serial stream every cycle; directed literals pin the model.
// Config   : PISO_LSB_FIRST_EN selects LSB-first expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso;

    localparam int WIDTH = 128;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] c_w1 = 128'habcdef0123456789abcdef0123456789;
    localparam logic [WIDTH-1:0] c_w2 = 128'h9876543210fedcba9876543210fedcba;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             data_o;
    logic             valid_o;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    piso #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .en     (en),
        .data_i (data_i),
        .data_o (data_o),
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    // Model: the captured word plus how many shifts have happened since load.
    logic [WIDTH-1:0] m_word = '0;
    int               m_k    = WIDTH;

    always @(posedge clk) begin
        if (!rst) begin
            m_word = '0;
            m_k    = WIDTH;
        end else if (load) begin
            m_word = data_i;
            m_k    = 0;
        end else if (en && m_k < WIDTH) begin
            m_k = m_k + 1;
        end
    end

    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k);
        if (k >= WIDTH) return 1'b0;
`ifdef PISO_LSB_FIRST_EN
        return w[k];
`else
        return w[WIDTH-1-k];
`endif
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            total++;
            if (data_o !== exp_bit(m_word, m_k) || valid_o !== (m_k < WIDTH)) begin
                bad++;
                $display("FAIL stream t=%0t data_o=%b valid_o=%b expected data_o=%b valid_o=%b",
                         $time, data_o, valid_o, exp_bit(m_word, m_k), (m_k < WIDTH));
            end
        end
    end

    logic obits[$];
    logic ovld[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Apply load/en for one edge and record the presented output.
    task automatic cyc(input logic l, input logic e);
        load = l;
        en   = e;
        @(negedge clk);
        obits.push_back(data_o);
        ovld.push_back(valid_o);
    endtask

    function automatic logic [7:0] pack8(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = obits[s+i];
        return b;
    endfunction

    logic [7:0] w1_first8, w1_last4, w2_first8;
    logic       pri_first, pri_second;
    logic       held_bit;
    logic [WIDTH-1:0] w2_copy;
    int         vcount;

    initial begin
`ifdef PISO_LSB_FIRST_EN
        w1_first8  = 8'b10010001;
        w1_last4   = 8'b00000101;
        w2_first8  = 8'b01011101;
        pri_first  = 1'b0;
        pri_second = 1'b1;
`else
        w1_first8  = 8'b10101011;
        w1_last4   = 8'b00001001;
        w2_first8  = 8'b10011000;
        pri_first  = 1'b1;
        pri_second = 1'b0;
`endif
        w2_copy = c_w2;

        // Reset dominates load and en.
        rst = 1'b0; load = 1'b1; en = 1'b1; data_i = '1;
        @(negedge clk);
        checking = 1'b1;
        check("reset_edge1", {6'd0, data_o, valid_o}, 8'd0);
        cyc(1'b1, 1'b1);
        check("reset_edge2", {6'd0, data_o, valid_o}, 8'd0);

        // Release reset, idle.
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("idle_after_reset", {6'd0, data_o, valid_o}, 8'd0);

        // First word: load then 127 shifts, garbage on data_i meanwhile.
        obits.delete(); ovld.delete();
        data_i = c_w1;
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 127; i++) begin
            data_i = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'b0, 1'b1);
        end
        check("w1_first8", pack8(0), w1_first8);
        check("w1_last4", {4'd0, obits[124], obits[125], obits[126], obits[127]}, w1_last4);
        vcount = 0;
        foreach (ovld[i]) if (ovld[i] === 1'b1) vcount++;
        check("w1_valid_count", 8'(vcount), 8'd128);

        // Back-to-back reload with en still high.
        obits.delete(); ovld.delete();
        data_i = c_w2;
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
        check("w2_first8", pack8(0), w2_first8);
        vcount = 0;
        foreach (ovld[i]) if (ovld[i] === 1'b1) vcount++;
        check("w2_valid_gapless", 8'(vcount), 8'd8);

        // Hold mid-word.
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
        held_bit = data_o;
        check("pre_hold_bit", {7'd0, held_bit}, {7'd0, exp_bit(w2_copy, 19)});
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            check("hold_frozen", {6'd0, data_o, valid_o}, {6'd0, held_bit, 1'b1});
        end
        cyc(1'b0, 1'b1);
        check("hold_resume", {6'd0, data_o, valid_o}, {6'd0, exp_bit(w2_copy, 20), 1'b1});

        // Drain to the end of the word and beyond.
        for (int i = 0; i < 107; i++) cyc(1'b0, 1'b1);
        check("w2_last_bit", {6'd0, data_o, valid_o}, {6'd0, exp_bit(w2_copy, 127), 1'b1});
        cyc(1'b0, 1'b1);
        check("after_width_shifts", {6'd0, data_o, valid_o}, 8'd0);
        cyc(1'b0, 1'b1);
        check("saturated_idle", {6'd0, data_o, valid_o}, 8'd0);

        // Early reload with load and en together: no shift, new head shown.
        data_i = c_w1;
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        data_i = c_w2;
        cyc(1'b1, 1'b1);
        check("load_priority_head", {6'd0, data_o, valid_o}, {6'd0, pri_first, 1'b1});
        cyc(1'b0, 1'b1);
        check("load_priority_next", {6'd0, data_o, valid_o}, {6'd0, pri_second, 1'b1});

        // Reset mid-word.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        rst = 1'b0;
        cyc(1'b0, 1'b1);
        check("reset_mid_word", {6'd0, data_o, valid_o}, 8'd0);
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        check("after_mid_reset", {6'd0, data_o, valid_o}, 8'd0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
